// File: rtl/dma_w_arbiter_pkg.sv
// Shared definitions for the DMA write-channel arbiter.
// State encodings and address-offset helpers.
package dma_w_arbiter_pkg;

   localparam int ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT  = 2'd1,
      ARB_ACTIVE = 2'd2,
      ARB_DRAIN  = 2'd3
   } arb_state_e;

   // Byte-offset bits below the data-word boundary.
   function automatic int calc_offset_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Width of a client index; never below one bit.
   function automatic int calc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_w_arbiter_pick.sv
// Round-robin first-one finder.
// Scans upward from the pointer with wrap-around.
module rr_priority_pick
   import dma_w_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = calc_idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Walk from farthest to nearest so the nearest valid client wins.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_valid[(int'(i_ptr) + k) % N_REQ]) begin
            o_idx = IDX_W'((int'(i_ptr) + k) % N_REQ);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_w_arbiter.sv
// Shares one aligner/DMA write channel between write clients.
// A grant lasts a whole job, until the DMA accepts its last beat.
module dma_w_arbiter
   import dma_w_arbiter_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   input  logic [N_REQ*(DATA_W/8)-1:0] req_wstrb,
   input  logic [N_REQ*ADDR_W-1:0]    req_end_addr,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       aln_valid,
   output logic [ADDR_W-1:0]          aln_addr,
   output logic [DATA_W-1:0]          aln_wdata,
   output logic [DATA_W/8-1:0]        aln_wstrb,
   input  logic                       aln_ready,
   output logic [ADDR_W-1:0]          aln_end_addr,
   output logic                       aln_clear,
   output logic                       aln_run,
   input  logic                       dma_w_valid,
   input  logic                       dma_w_ready,
   input  logic [ADDR_W-1:0]          dma_w_addr,
   output logic [N_REQ-1:0]           grant,
   output logic                       busy,
   output logic                       job_done
);

   localparam int OFFSET_W = calc_offset_w(DATA_W);
   localparam int STRB_W   = DATA_W / 8;
   localparam int IDX_W    = calc_idx_w(N_REQ);

   arb_state_e         r_state;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   r_rr;
   logic [ADDR_W-1:0]  r_end;
   logic [N_REQ-1:0]   r_grant;
   logic               r_busy;
   logic               r_job_done;
   logic               r_clear;
   logic               r_run;

   logic [ADDR_W-1:0]  w_addr_a [N_REQ];
   logic [DATA_W-1:0]  w_data_a [N_REQ];
   logic [STRB_W-1:0]  w_strb_a [N_REQ];
   logic [ADDR_W-1:0]  w_end_a  [N_REQ];

   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_any;
   logic [N_REQ-1:0]   w_pick_hot;
   logic [IDX_W-1:0]   w_rr_next;
   logic               w_active;
   logic               w_own_valid;
   logic [ADDR_W-1:0]  w_own_addr;
   logic               w_beat_last;
   logic               w_dma_last;
   logic               w_unused;

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign w_addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign w_data_a[g] = req_wdata[g*DATA_W +: DATA_W];
      assign w_strb_a[g] = req_wstrb[g*STRB_W +: STRB_W];
      assign w_end_a[g]  = req_end_addr[g*ADDR_W +: ADDR_W];
   end

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_valid (req_valid),
      .i_ptr   (r_rr),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_pick_hot  = N_REQ'(1) << w_pick_idx;
   assign w_rr_next   = (r_owner == IDX_W'(N_REQ - 1)) ?
                        '0 : r_owner + 1'b1;

   assign w_active    = (r_state == ARB_ACTIVE);
   assign w_own_valid = req_valid[r_owner];
   assign w_own_addr  = w_addr_a[r_owner];

   // >= rather than == so a client end below its start still terminates.
   assign w_beat_last = w_active & w_own_valid & aln_ready &
                        (w_own_addr[ADDR_W-1:OFFSET_W] >=
                         r_end[ADDR_W-1:OFFSET_W]);

   assign w_dma_last  = dma_w_valid & dma_w_ready &
                        (dma_w_addr[ADDR_W-1:OFFSET_W] >=
                         r_end[ADDR_W-1:OFFSET_W]);

   // The DMA side is word aligned; its byte offset carries no meaning.
   assign w_unused    = ^dma_w_addr[OFFSET_W-1:0];

   assign aln_valid    = w_active & w_own_valid;
   assign aln_addr     = w_own_addr;
   assign aln_wdata    = w_data_a[r_owner];
   assign aln_wstrb    = w_strb_a[r_owner];
   assign aln_end_addr = r_end;
   assign aln_clear    = r_clear;
   assign aln_run      = r_run;
   assign grant        = r_grant;
   assign busy         = r_busy;
   assign job_done     = r_job_done;

   // Only the owner sees the aligner's ready, and only while ACTIVE.
   always_comb begin
      req_ready = '0;
      if (w_active) begin
         req_ready[r_owner] = aln_ready;
      end
   end

   // Job FSM: pick in IDLE, configure in GRANT, stream, wait for DMA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_owner    <= '0;
         r_rr       <= '0;
         r_end      <= '0;
         r_grant    <= '0;
         r_busy     <= 1'b0;
         r_job_done <= 1'b0;
         r_clear    <= 1'b0;
         r_run      <= 1'b0;
      end else begin
         r_job_done <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_any) begin
                  r_state <= ARB_GRANT;
                  r_owner <= w_pick_idx;
                  r_end   <= w_end_a[w_pick_idx];
                  r_grant <= w_pick_hot;
                  r_busy  <= 1'b1;
                  r_clear <= 1'b1;
                  r_run   <= 1'b1;
               end
            end
            ARB_GRANT: begin
               r_state <= ARB_ACTIVE;
               r_clear <= 1'b0;
               r_run   <= 1'b0;
            end
            ARB_ACTIVE: begin
               if (w_beat_last) begin
                  r_state <= ARB_DRAIN;
               end
            end
            ARB_DRAIN: begin
               if (w_dma_last) begin
                  r_state    <= ARB_IDLE;
                  r_grant    <= '0;
                  r_busy     <= 1'b0;
                  r_job_done <= 1'b1;
                  r_rr       <= w_rr_next;
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_w_arbiter.sv
// Self-checking bench for dma_w_arbiter.
// Job-level reference model plus directed and random traffic.
module tb_dma_w_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N*SW-1:0] req_wstrb = '0;
   logic [N*AW-1:0] req_end_addr = '0;
   logic [N-1:0]    req_ready;
   logic            aln_valid;
   logic [AW-1:0]   aln_addr;
   logic [DW-1:0]   aln_wdata;
   logic [SW-1:0]   aln_wstrb;
   logic            aln_ready = 1'b0;
   logic [AW-1:0]   aln_end_addr;
   logic            aln_clear;
   logic            aln_run;
   logic            dma_w_valid = 1'b0;
   logic            dma_w_ready = 1'b0;
   logic [AW-1:0]   dma_w_addr = '0;
   logic [N-1:0]    grant;
   logic            busy;
   logic            job_done;

   dma_w_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_wstrb    (req_wstrb),
      .req_end_addr (req_end_addr),
      .req_ready    (req_ready),
      .aln_valid    (aln_valid),
      .aln_addr     (aln_addr),
      .aln_wdata    (aln_wdata),
      .aln_wstrb    (aln_wstrb),
      .aln_ready    (aln_ready),
      .aln_end_addr (aln_end_addr),
      .aln_clear    (aln_clear),
      .aln_run      (aln_run),
      .dma_w_valid  (dma_w_valid),
      .dma_w_ready  (dma_w_ready),
      .dma_w_addr   (dma_w_addr),
      .grant        (grant),
      .busy         (busy),
      .job_done     (job_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 idle, 1 configuring, 2 streaming, 3 draining.
   int          m_ph = 0;
   int          m_own = 0;
   int          m_rr = 0;
   logic [31:0] m_end = '0;
   bit          m_done = 0;
   int          m_jobs = 0;
   int          m_beats = 0;
   int          m_drain = 0;
   logic [31:0] m_last = '0;
   int          m_order[$];
   int          n_clear = 0;
   int          n_done = 0;

   // Client / monitor stimulus state.
   logic [31:0] c_addr[N];
   logic [31:0] c_end[N];
   bit          c_on[N];
   bit          c_reload[N];
   int          c_hold[N];
   bit          hs[N];
   bit          d_hs;
   bit          rand_drop = 0;
   int          rdy_mode = 0;
   int          dma_mode = 0;
   int          d_cnt = 0;
   logic [31:0] d_base = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison, then advance the model by one clock.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         model_cycle();
      end
   end

   task automatic model_cycle();
      logic [N-1:0] e_grant;
      logic [N-1:0] e_rdy;
      logic         e_valid;
      logic [31:0]  oa;
      bit           found;
      if (rst) begin
         m_ph = 0; m_own = 0; m_rr = 0;
         m_end = '0; m_done = 0;
      end
      e_grant = (m_ph != 0) ? N'(1 << m_own) : '0;
      e_valid = (m_ph == 2) && req_valid[m_own];
      e_rdy   = (m_ph == 2 && aln_ready) ? N'(1 << m_own) : '0;
      oa      = req_addr[m_own*AW +: AW];
      chk("grant", grant, e_grant);
      chk("busy", busy, m_ph != 0);
      chk("job_done", job_done, m_done);
      chk("aln_clear", aln_clear, m_ph == 1);
      chk("aln_run", aln_run, m_ph == 1);
      chk("aln_end_addr", aln_end_addr, m_end);
      chk("aln_valid", aln_valid, e_valid);
      chk("req_ready", req_ready, e_rdy);
      if (e_valid) begin
         chk("aln_addr", aln_addr, oa);
         chk("aln_wdata", aln_wdata, req_wdata[m_own*DW +: DW]);
         chk("aln_wstrb", aln_wstrb, req_wstrb[m_own*SW +: SW]);
      end
      if (aln_clear) n_clear++;
      if (job_done) n_done++;
      if (!rst) begin
         m_done = 0;
         case (m_ph)
            0: begin
               found = 0;
               for (int k = 0; k < N; k++) begin
                  if (!found && req_valid[(m_rr + k) % N]) begin
                     found = 1;
                     m_own = (m_rr + k) % N;
                  end
               end
               if (found) begin
                  m_end = req_end_addr[m_own*AW +: AW];
                  m_ph = 1;
                  m_order.push_back(m_own);
               end
            end
            1: m_ph = 2;
            2: begin
               if (e_valid && aln_ready) begin
                  m_beats++;
                  m_last = oa;
                  if ((oa >> 2) >= (m_end >> 2)) m_ph = 3;
               end
            end
            default: begin
               m_drain++;
               if (dma_w_valid && dma_w_ready &&
                   (dma_w_addr >> 2) >= (m_end >> 2)) begin
                  m_ph = 0;
                  m_done = 1;
                  m_rr = (m_own + 1) % N;
                  m_jobs++;
               end
            end
         endcase
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = c_on[i] && (c_hold[i] == 0) &&
                        !(rand_drop && $urandom_range(0, 3) == 0);
         req_addr[i*AW +: AW]     = c_addr[i];
         req_end_addr[i*AW +: AW] = c_end[i];
         req_wdata[i*DW +: DW]    = $urandom;
         req_wstrb[i*SW +: SW]    = SW'($urandom);
      end
      case (rdy_mode)
         0:       aln_ready = 1'b1;
         1:       aln_ready = ~aln_ready;
         default: aln_ready = 1'($urandom_range(0, 1));
      endcase
      case (dma_mode)
         1: begin
            dma_w_valid = (m_ph == 3);
            dma_w_ready = 1'b1;
            dma_w_addr  = d_base + 32'(d_cnt * 4);
         end
         2: begin
            dma_w_valid = 1'($urandom_range(0, 1));
            dma_w_ready = 1'($urandom_range(0, 1));
            dma_w_addr  = ((m_end >> 2) + 32'($urandom_range(0, 2))
                          - 32'd1) << 2;
         end
         default: begin
            dma_w_valid = 1'b0;
            dma_w_ready = 1'b0;
            dma_w_addr  = $urandom;
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #3;
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
      d_hs = dma_w_valid && dma_w_ready;
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               if ((c_addr[i] >> 2) >= (c_end[i] >> 2)) begin
                  if (c_reload[i]) new_job(i);
                  else c_on[i] = 0;
               end else begin
                  c_addr[i] = c_addr[i] + 32'd4;
               end
            end
         end
         if (dma_mode == 1 && d_hs) d_cnt++;
      end
      for (int i = 0; i < N; i++) if (c_hold[i] > 0) c_hold[i]--;
   endtask

   task automatic set_job(input int i, input logic [31:0] s,
                          input logic [31:0] e, input bit rl);
      c_addr[i] = s; c_end[i] = e;
      c_on[i] = 1; c_reload[i] = rl; c_hold[i] = 0;
   endtask

   task automatic new_job(input int i);
      logic [31:0] s;
      int          len;
      s = 32'(i + 1) * 32'h1000 + 32'($urandom_range(0, 63)) * 4 +
          32'($urandom_range(0, 3));
      len = $urandom_range(0, 5);
      c_addr[i] = s;
      if ($urandom_range(0, 9) == 0) c_end[i] = s - 32'd8;
      else c_end[i] = s + 32'(len * 4) + 32'($urandom_range(0, 3));
      c_on[i] = 1; c_hold[i] = 0;
   endtask

   task automatic wait_more(input int n, input int budget);
      int target = m_jobs + n;
      int k = 0;
      while (m_jobs < target && k < budget) begin
         step();
         k++;
      end
      chk("job_timeout", m_jobs >= target, 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((m_ph != 0 || c_on[0] || c_on[1]) && k < budget) begin
         step();
         k++;
      end
      chk("idle_timeout", m_ph == 0 && !c_on[0] && !c_on[1], 1);
   endtask

   task automatic wait_ph(input int ph, input int budget);
      int k = 0;
      while (m_ph != ph && k < budget) begin
         step();
         k++;
      end
      chk("phase_timeout", m_ph, ph);
   endtask

   initial begin
      int b_beats, b_drain, b_clear, b_done, b_ord;
      for (int i = 0; i < N; i++) begin
         c_addr[i] = '0; c_end[i] = '0; c_on[i] = 0;
         c_reload[i] = 0; c_hold[i] = 0; hs[i] = 0;
      end
      #1 rst = 1'b1;
      repeat (3) step();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", job_done, 0);
      chk("rst_valid", aln_valid, 0);
      chk("rst_clear", aln_clear, 0);
      chk("rst_run", aln_run, 0);
      chk("rst_ready", req_ready, 0);

      // Single 4-beat job for client 0.
      set_job(0, 32'h100, 32'h10F, 0);
      rdy_mode = 0; dma_mode = 1; d_base = 32'h100; d_cnt = 0;
      b_beats = m_beats; b_drain = m_drain; b_clear = n_clear;
      b_done = n_done; b_ord = m_order.size();
      rst = 1'b0;
      wait_more(1, 100);
      chk("t1_grant_off", grant, 0);
      chk("t1_done_hi", job_done, 1);
      chk("t1_busy_off", busy, 0);
      step();
      chk("t1_done_lo", job_done, 0);
      chk("t1_beats", m_beats - b_beats, 4);
      chk("t1_drain", m_drain - b_drain, 4);
      chk("t1_last", m_last, 32'h10C);
      chk("t1_clears", n_clear - b_clear, 1);
      chk("t1_dones", n_done - b_done, 1);
      chk("t1_owner", m_order[b_ord], 0);

      // Both clients valid at reset release: alternation 0,1,0.
      rst = 1'b1;
      step();
      set_job(0, 32'h400, 32'h407, 1);
      set_job(1, 32'h500, 32'h507, 0);
      dma_mode = 2;
      b_ord = m_order.size();
      rst = 1'b0;
      wait_more(3, 400);
      chk("t2_first", m_order[b_ord], 0);
      chk("t2_second", m_order[b_ord+1], 1);
      chk("t2_third", m_order[b_ord+2], 0);
      c_reload[0] = 0;
      wait_idle(400);

      // Owner stalls for 3 cycles while client 1 waits.
      set_job(0, 32'h300, 32'h31F, 0);
      b_beats = m_beats;
      wait_ph(2, 20);
      set_job(1, 32'h600, 32'h603, 0);
      step(); step();
      c_hold[0] = 3;
      b_ord = m_order.size();
      repeat (3) begin
         step();
         chk("t3_hold_grant", grant, 2'b01);
         chk("t3_hold_rdy1", req_ready[1], 0);
      end
      wait_more(2, 400);
      chk("t3_next", m_order[b_ord], 1);
      chk("t3_beats", m_beats - b_beats, 9);
      wait_idle(400);

      // aln_ready toggling every cycle.
      set_job(0, 32'h100, 32'h10F, 0);
      rdy_mode = 1;
      b_beats = m_beats;
      wait_more(1, 400);
      chk("t4_beats", m_beats - b_beats, 4);
      chk("t4_last_word", m_last >> 2, 32'h43);
      wait_idle(100);

      // Single-beat job.
      set_job(0, 32'h203, 32'h203, 0);
      rdy_mode = 0; dma_mode = 1; d_base = 32'h200; d_cnt = 0;
      b_beats = m_beats; b_drain = m_drain;
      wait_more(1, 100);
      chk("t5_beats", m_beats - b_beats, 1);
      chk("t5_drain", m_drain - b_drain, 1);
      chk("t5_last", m_last, 32'h203);
      wait_idle(100);

      // Random traffic.
      rand_drop = 1; rdy_mode = 2; dma_mode = 2;
      b_done = m_jobs;
      for (int i = 0; i < N; i++) begin
         c_reload[i] = 1;
         new_job(i);
      end
      repeat (3000) step();
      c_reload[0] = 0; c_reload[1] = 0;
      wait_idle(3000);
      chk("t6_progress", m_jobs > b_done + 20, 1);
      rand_drop = 0;

      // Reset while draining.
      set_job(0, 32'h700, 32'h70F, 0);
      rdy_mode = 0; dma_mode = 0;
      wait_ph(3, 50);
      rst = 1'b1;
      step();
      chk("t7_grant", grant, 0);
      chk("t7_busy", busy, 0);
      chk("t7_clear", aln_clear, 0);
      chk("t7_run", aln_run, 0);
      chk("t7_valid", aln_valid, 0);
      chk("t7_end", aln_end_addr, 0);
      set_job(0, 32'h800, 32'h803, 0);
      set_job(1, 32'h900, 32'h903, 0);
      dma_mode = 2;
      b_ord = m_order.size();
      rst = 1'b0;
      step();
      step();
      chk("t7_regrant", grant, 2'b01);
      wait_more(2, 400);
      chk("t7_first", m_order[b_ord], 0);
      chk("t7_second", m_order[b_ord+1], 1);
      wait_idle(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
